dma_priority_resolver: RTL and testbench

//   Request/priority front end of the 4-channel DMA controller.
//   - Qualifies DREQ, software requests and mask bits.
//   - Runs the HRQ/HLDA hold handshake with the CPU.
//   - Resolves one winning channel (fixed or rotating priority) and drives
//     one-hot DACK.
//   - Holds the grant until the timing-control stage reports end of service.

---
 rtl/dma_pkg.sv | 34 +++
 rtl/dma_priority_encoder.sv | 29 ++
 rtl/dma_priority_resolver.sv | 96 +++++++++
 tb/tb_dma_priority_resolver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA request/priority front end.
// rotate_order() implements the rotating-priority update applied after a completed service.
package dma_pkg;

  localparam int NUM_CH = 4;
  localparam int CHW = 2;
  localparam logic [7:0] DEFAULT_ORDER = 8'b11_10_01_00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // The serviced channel moves to field3; the others keep their cyclic order ahead of it.
  function automatic logic [7:0] rotate_order(input logic [7:0] order,
                                              input logic [CHW-1:0] ch);
    logic [CHW-1:0] k;
    logic [CHW-1:0] src;
    logic [7:0] r;
    k = '0;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (order[2*i +: 2] == ch) k = CHW'(i);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      src = k + CHW'(i) + CHW'(1);
      r[2*i +: 2] = order[2*src +: 2];
    end
    return r;
  endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational winner select: first field of the order (field0 first) whose channel requests.
module dma_priority_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [7:0]        order,
  output logic [CHW-1:0]    winner,
  output logic              any_req
);

  logic found;
  logic [CHW-1:0] ch;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    ch     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch = order[2*i +: 2];
      if (!found && req[ch]) begin
        winner = ch;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/dma_priority_resolver.sv
// Request qualification, HRQ/HLDA hold handshake and channel grant for the 4-channel DMA.
// All outputs are registered; the grant is locked until service ends or the hold is lost.
module dma_priority_resolver
  import dma_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  DREQ,
  input  logic        HLDA,
  input  logic [3:0]  maskReg,
  input  logic [3:0]  requestReg,
  input  logic        priorityType,
  input  logic        dreqSenseLow,
  input  logic        controllerDisable,
  input  logic        serviceDone,
  output logic        HRQ,
  output logic [3:0]  DACK,
  output logic [1:0]  activeChannel,
  output logic        grantValid,
  output logic [7:0]  priorityOrder
);

  state_t state;
  logic [NUM_CH-1:0] eff_req;
  logic [CHW-1:0] winner;
  logic any_req;

  assign eff_req = ((DREQ ^ {NUM_CH{dreqSenseLow}}) | requestReg)
                   & ~maskReg & {NUM_CH{!controllerDisable}};

  dma_priority_encoder u_enc (
    .req     (eff_req),
    .order   (priorityOrder),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      HRQ           <= 1'b0;
      DACK          <= '0;
      grantValid    <= 1'b0;
      activeChannel <= '0;
      priorityOrder <= DEFAULT_ORDER;
    end else begin
      case (state)
        IDLE: begin
          if (!priorityType) priorityOrder <= DEFAULT_ORDER;
          if (any_req) begin
            state <= REQ;
            HRQ   <= 1'b1;
          end else begin
            HRQ <= 1'b0;
          end
        end
        REQ: begin
          // Withdrawal takes precedence over a simultaneous HLDA.
          if (!any_req) begin
            state <= IDLE;
            HRQ   <= 1'b0;
          end else if (HLDA) begin
            state         <= GRANT;
            DACK          <= 4'b0001 << winner;
            grantValid    <= 1'b1;
            activeChannel <= winner;
          end
        end
        GRANT: begin
          if (serviceDone) begin
            state      <= RELEASE;
            HRQ        <= 1'b0;
            DACK       <= '0;
            grantValid <= 1'b0;
            if (priorityType) priorityOrder <= rotate_order(priorityOrder, activeChannel);
          end else if (!HLDA || controllerDisable) begin
            state      <= IDLE;
            HRQ        <= 1'b0;
            DACK       <= '0;
            grantValid <= 1'b0;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          HRQ        <= 1'b0;
          DACK       <= '0;
          grantValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed bench for dma_priority_resolver with hand-computed expectations.
module tb_dma_priority_resolver;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic       HLDA;
  logic [3:0] maskReg;
  logic [3:0] requestReg;
  logic       priorityType;
  logic       dreqSenseLow;
  logic       controllerDisable;
  logic       serviceDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] activeChannel;
  logic       grantValid;
  logic [7:0] priorityOrder;

  int n_assert = 0;
  int n_fail = 0;

  dma_priority_resolver dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .DREQ              (DREQ),
    .HLDA              (HLDA),
    .maskReg           (maskReg),
    .requestReg        (requestReg),
    .priorityType      (priorityType),
    .dreqSenseLow      (dreqSenseLow),
    .controllerDisable (controllerDisable),
    .serviceDone       (serviceDone),
    .HRQ               (HRQ),
    .DACK              (DACK),
    .activeChannel     (activeChannel),
    .grantValid        (grantValid),
    .priorityOrder     (priorityOrder)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; DREQ = '0; HLDA = 1'b0; maskReg = '0; requestReg = '0;
    priorityType = 1'b0; dreqSenseLow = 1'b0; controllerDisable = 1'b0; serviceDone = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    chk("rst_hrq", {7'd0, HRQ}, 8'd0);
    chk("rst_dack", {4'd0, DACK}, 8'h00);
    chk("rst_gv", {7'd0, grantValid}, 8'd0);
    chk("rst_ac", {6'd0, activeChannel}, 8'd0);
    chk("rst_order", priorityOrder, 8'hE4);

    // Fixed priority, channels 1..3 requesting; HLDA three cycles after request.
    DREQ = 4'b1110;
    tick();
    chk("fix_hrq", {7'd0, HRQ}, 8'd1);
    chk("fix_dack_pre", {4'd0, DACK}, 8'h00);
    tick(); tick();
    HLDA = 1'b1;
    tick();
    chk("fix_dack", {4'd0, DACK}, 8'h02);
    chk("fix_ac", {6'd0, activeChannel}, 8'd1);
    chk("fix_gv", {7'd0, grantValid}, 8'd1);
    maskReg = 4'b0010;
    tick();
    chk("fix_locked", {4'd0, DACK}, 8'h02);
    serviceDone = 1'b1;
    tick();
    chk("fix_rel_dack", {4'd0, DACK}, 8'h00);
    chk("fix_rel_hrq", {7'd0, HRQ}, 8'd0);
    chk("fix_rel_order", priorityOrder, 8'hE4);
    serviceDone = 1'b0; DREQ = '0; HLDA = 1'b0; maskReg = '0;
    tick(); tick();

    // Rotating priority, all channels requesting, ch0 serviced.
    priorityType = 1'b1; DREQ = 4'b1111;
    tick();
    HLDA = 1'b1;
    tick();
    chk("rot_dack0", {4'd0, DACK}, 8'h01);
    serviceDone = 1'b1;
    tick();
    chk("rot_rel_dack", {4'd0, DACK}, 8'h00);
    chk("rot_rel_gv", {7'd0, grantValid}, 8'd0);
    chk("rot_order", priorityOrder, 8'h39);
    serviceDone = 1'b0;
    tick(); tick(); tick();
    chk("rot_dack1", {4'd0, DACK}, 8'h02);
    chk("rot_ac1", {6'd0, activeChannel}, 8'd1);
    HLDA = 1'b0;
    tick();
    chk("abort_dack", {4'd0, DACK}, 8'h00);
    chk("abort_order", priorityOrder, 8'h39);

    // Asynchronous reset while a grant is active.
    tick();
    HLDA = 1'b1;
    tick();
    chk("pre_rst_dack", {4'd0, DACK}, 8'h02);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_hrq", {7'd0, HRQ}, 8'd0);
    chk("mid_rst_dack", {4'd0, DACK}, 8'h00);
    chk("mid_rst_gv", {7'd0, grantValid}, 8'd0);
    chk("mid_rst_order", priorityOrder, 8'hE4);
    RESET = 1'b0; HLDA = 1'b0;

    // HLDA drop during ch0 grant in rotating mode: no rotation.
    tick();
    HLDA = 1'b1;
    tick();
    chk("drop_dack0", {4'd0, DACK}, 8'h01);
    HLDA = 1'b0;
    tick();
    chk("drop_dack", {4'd0, DACK}, 8'h00);
    chk("drop_order", priorityOrder, 8'hE4);
    DREQ = '0; priorityType = 1'b0;
    tick(); tick();

    // Masked hardware request, then an unmasked software request.
    maskReg = 4'b0001; DREQ = 4'b0001;
    tick(); tick();
    chk("mask_hrq", {7'd0, HRQ}, 8'd0);
    requestReg = 4'b0100;
    tick();
    chk("sw_hrq", {7'd0, HRQ}, 8'd1);
    HLDA = 1'b1;
    tick();
    chk("sw_dack", {4'd0, DACK}, 8'h04);
    chk("sw_ac", {6'd0, activeChannel}, 8'd2);
    requestReg = '0; DREQ = '0; maskReg = '0; HLDA = 1'b0;
    tick(); tick();

    // Request withdrawn before HLDA.
    DREQ = 4'b0001;
    tick();
    chk("wd_hrq1", {7'd0, HRQ}, 8'd1);
    tick();
    chk("wd_hrq2", {7'd0, HRQ}, 8'd1);
    chk("wd_dack", {4'd0, DACK}, 8'h00);
    DREQ = '0;
    tick();
    chk("wd_hrq_fall", {7'd0, HRQ}, 8'd0);
    chk("wd_dack_end", {4'd0, DACK}, 8'h00);
    tick();

    // Active-low DREQ; completion coinciding with HLDA drop still rotates.
    dreqSenseLow = 1'b1; DREQ = 4'b1111; priorityType = 1'b1;
    tick(); tick();
    chk("low_idle_hrq", {7'd0, HRQ}, 8'd0);
    DREQ = 4'b1011;
    tick();
    HLDA = 1'b1;
    tick();
    chk("low_dack", {4'd0, DACK}, 8'h04);
    serviceDone = 1'b1; HLDA = 1'b0;
    tick();
    chk("sd_drop_dack", {4'd0, DACK}, 8'h00);
    chk("sd_drop_order", priorityOrder, 8'h93);
    serviceDone = 1'b0; DREQ = 4'b1111;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
